// File: rtl/filter_sample_feeder.sv
// filter_sample_feeder: synchronizes switch inputs, samples them at a programmable rate
// and buffers the samples in a first-word-fall-through FIFO with a valid/ready output.
module filter_sample_feeder #(
   parameter int DATA_W      = 8,
   parameter int DIV_W       = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             raw_in,
   input  logic                          enable,
   input  logic [DIV_W-1:0]              div_ratio,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          overflow_clr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

   logic [DATA_W-1:0] sync_q [SYNC_STAGES];
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DIV_W-1:0]  cnt_q, cnt_d, thr;
   logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]       level_q, level_d;
   logic              overflow_q, overflow_d;
   logic              strobe, full, push, pop;

   // Threshold compare (>=) lets a shrinking div_ratio take effect without a long wrap.
   always_comb begin
      full       = level_q == FULL;
      thr        = (div_ratio <= DIV_W'(1)) ? '0 : div_ratio - DIV_W'(1);
      strobe     = enable && cnt_q >= thr;
      cnt_d      = (!enable || strobe) ? '0 : cnt_q + DIV_W'(1);
      pop        = out_valid && out_ready;
      push       = strobe && (!full || pop);
      wr_d       = push ? wr_q + AW'(1) : wr_q;
      rd_d       = pop ? rd_q + AW'(1) : rd_q;
      level_d    = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow_d = (strobe && full && !pop) || (overflow_q && !overflow_clr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         cnt_q      <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         sync_q[0] <= raw_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         if (push) mem_q[wr_q] <= sync_q[SYNC_STAGES-1];
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   assign out_data   = mem_q[rd_q];
   assign out_valid  = level_q != '0;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
endmodule

// File: doc/filter_sample_feeder.md
Name: filter_sample_feeder

Overview:
Upstream stage of the 4-tap FIR filter. Synchronizes the asynchronous 8-bit switch input and samples it at a programmable rate. Buffers the captured samples in a small FIFO and presents them to the filter over a valid/ready handshake. The filter therefore sees a clean, rate-controlled sample stream instead of sampling the raw pins every clock.

Parameters:
DATA_W, 8, sample width in bits
DIV_W, 16, width of the sample-period divider
FIFO_DEPTH, 4, FIFO entries; must be a power of two and at least 2
SYNC_STAGES, 2, flip-flop stages in the input synchronizer; must be at least 2

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
raw_in  input  DATA_W  asynchronous switch inputs
enable  input  1  1 = sampling active
div_ratio  input  DIV_W  sample period in clk cycles; 0 and 1 both mean every cycle
out_data  output  DATA_W  FIFO head sample
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts the head sample
fifo_level  output  clog2(FIFO_DEPTH)+1  number of occupied entries
overflow  output  1  sticky flag: a sample was dropped
overflow_clr  input  1  clears overflow

Behaviour:
- Clock is clk. Reset is reset, asynchronous, active-high.
- Reset forces, immediately and without a clock edge:
  - synchronizer flops = 0, rate counter = 0
  - FIFO empty, read and write pointers = 0
  - out_valid = 0, out_data = 0, fifo_level = 0, overflow = 0
- Reset mid-operation discards all buffered samples.
- Synchronizer:
  - raw_in passes through SYNC_STAGES flops; the last stage is sync_data.
  - No multi-bit coherency guarantee; a switch change may be captured across two samples.
- Rate counter (DIV_W bits):
  - enable = 0: counter held at 0, no strobes.
  - enable = 1: strobe is asserted when counter >= div_ratio-1 (treat div_ratio <= 1 as threshold 0). On a strobe the counter wraps to 0; otherwise it increments.
  - The ">=" compare makes a div_ratio decrease take effect within one cycle with no long wrap.
  - Constant div_ratio = N gives exactly one strobe every N cycles.
  - The first strobe after reset release or enable rise occurs on the N-th enabled cycle.
- FIFO write: on a strobe, sync_data is written at the write pointer if a slot is free.
- FIFO read:
  - First-word-fall-through: out_data = entry at the read pointer, out_valid = (level != 0).
  - Pop occurs when out_valid && out_ready.
  - out_data is undefined when out_valid = 0; the RTL drives the stale entry, or 0 after reset.
- Write/read latency:
  - A sample written at edge k is visible on out_valid/out_data after edge k.
  - raw_in to out_data: SYNC_STAGES cycles plus wait-for-strobe plus 1.
- Level update: level' = level + push - pop. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop:
  - Level unchanged.
  - When full, the pop frees the slot in the same cycle, so the push succeeds and there is no overflow.
  - When empty, pop is impossible (out_valid = 0), so only the push occurs.
- Full without pop on a strobe: sample dropped, FIFO contents unchanged, overflow set to 1.
- overflow:
  - Cleared by overflow_clr = 1.
  - If a drop and overflow_clr occur in the same cycle, set wins: overflow = 1.
- enable falling mid-run: counter returns to 0, no further writes; buffered samples remain and drain normally.
- out_ready ignored while out_valid = 0.
- Arithmetic: unsigned throughout; no saturation needed (level bounded by the full check).

Test Plan:
1. Basic rate:
   - Stimulus: reset 3 cycles, raw_in = 0x3C held, enable = 1, div_ratio = 4, out_ready = 1.
   - Required: out_valid high for exactly 1 cycle in every 4; out_data = 0x3C; fifo_level alternates 0/1; overflow stays 0.
2. Fill and overflow:
   - Stimulus: out_ready = 0, div_ratio = 1, raw_in stepped 0x01, 0x02, 0x03 … one value per cycle (held ≥ SYNC_STAGES ahead).
   - Required: fifo_level reaches 4; the next strobe sets overflow = 1 with level still 4.
   - Then out_ready = 1: pops return the four earliest captured values in order; level ends at 0.
3. Full with simultaneous pop:
   - Stimulus: FIFO full at level 4, div_ratio = 1, out_ready = 1 for one cycle.
   - Required: level stays 4, overflow stays 0, head advances by one entry, new sample appended at the tail.
4. Overflow clear priority:
   - Stimulus: overflow = 1, pulse overflow_clr with FIFO not full.
   - Required: overflow = 0 the next cycle.
   - Stimulus: repeat while full with a strobe and no pop.
   - Required: overflow remains 1.
5. Enable drop:
   - Stimulus: level 3, enable → 0, out_ready = 1.
   - Required: three pops of the buffered values, no new writes, level 0; the counter restarts so the first strobe comes div_ratio cycles after enable returns to 1.
6. Async reset mid-run:
   - Stimulus: assert reset between clock edges with level 3 and overflow = 1.
   - Required: out_valid, fifo_level and overflow go to 0 before the next clk edge.
   - After release, with div_ratio = 2: first out_valid on the 2nd enabled cycle plus 1.
